// File: rtl/tx_skp_scheduler.sv
// tx_skp_scheduler: merges MAC symbols with periodic COM+SKP ordered sets, never splitting a packet
module tx_skp_scheduler #(
   parameter int SKP_INTERVAL = 1180,
   parameter int SKP_COUNT    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_k,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_k,
   output logic       skp_pending,
   output logic       skp_sent,
   output logic       tx_underrun
);
   localparam int CW = $clog2(SKP_INTERVAL + 1);
   localparam logic [CW-1:0] CMAX = CW'(SKP_INTERVAL - 1);
   localparam logic [2:0] IMAX = 3'(SKP_COUNT - 1);
   typedef enum logic [1:0] {PASS, IN_PKT, SKP_SYM} state_t;
   state_t r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [2:0] r_idx;
   logic [7:0] r_data, w_data;
   logic r_k, w_k, r_sent, w_sent, r_unf, w_unf;
   logic w_pend, w_com, w_xfer;
   assign w_pend      = (r_cnt == CMAX) && (r_state != SKP_SYM);
   assign in_ready    = !reset && (r_state == IN_PKT || (r_state == PASS && !w_pend));
   assign w_xfer      = in_valid && in_ready;
   assign w_com       = (r_state == PASS) && w_pend;
   assign out_data    = r_data;
   assign out_k       = r_k;
   assign skp_pending = w_pend;
   assign skp_sent    = r_sent;
   assign tx_underrun = r_unf;
   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= PASS;
      else       r_state <= w_next;
   end
   // next state: insertion only starts from PASS, so packets are never split
   always_comb begin
      w_next = r_state;
      case (r_state)
         PASS:    w_next = w_com ? SKP_SYM : (w_xfer && !in_last) ? IN_PKT : PASS;
         IN_PKT:  w_next = (w_xfer && in_last) ? PASS : IN_PKT;
         SKP_SYM: w_next = (r_idx == IMAX) ? PASS : SKP_SYM;
         default: w_next = PASS;
      endcase
   end
   // next output symbol and pulses, registered below for one-cycle latency
   always_comb begin
      w_data = 8'h00;
      w_k    = 1'b0;
      w_sent = 1'b0;
      w_unf  = 1'b0;
      if (r_state == SKP_SYM) begin
         w_data = 8'h1C;
         w_k    = 1'b1;
         w_sent = (r_idx == IMAX);
      end else if (w_com) begin
         w_data = 8'hBC;
         w_k    = 1'b1;
      end else if (w_xfer) begin
         w_data = in_data;
         w_k    = in_k;
      end else begin
         w_unf = (r_state == IN_PKT);
      end
   end
   // output registers, saturating interval counter and SKP index
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data  <= 8'h00;
         r_k     <= 1'b0;
         r_sent  <= 1'b0;
         r_unf   <= 1'b0;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_data  <= w_data;
         r_k     <= w_k;
         r_sent  <= w_sent;
         r_unf   <= w_unf;
         r_cnt   <= w_com ? '0 : (r_cnt == CMAX) ? r_cnt : r_cnt + 1'b1;
         r_idx   <= (r_state == SKP_SYM) ? r_idx + 3'd1 : 3'd0;
      end
   end
endmodule

// File: tb/tb_tx_skp_scheduler.sv
// tb_tx_skp_scheduler: directed checks of SKP scheduling, packet deferral, underrun and reset
module tb_tx_skp_scheduler;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_k = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_k;
   logic       skp_pending;
   logic       skp_sent;
   logic       tx_underrun;
   int         n_chk = 0;
   int         n_fail = 0;

   tx_skp_scheduler #(.SKP_INTERVAL(16), .SKP_COUNT(3)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_k(in_k), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_k(out_k),
      .skp_pending(skp_pending), .skp_sent(skp_sent), .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [8:0] sym(input logic k, input logic [7:0] d);
      return {k, d};
   endfunction

   logic [7:0] pd [7];
   logic       pk [7];
   logic       pv [7];
   logic       pl [7];

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_out", sym(out_k, out_data), 9'h000);
      chk("rst_ready", in_ready, 0);
      chk("rst_sent", skp_sent, 0);
      chk("rst_unf", tx_underrun, 0);
      chk("rst_pend", skp_pending, 0);

      // idle link: COM at edge 16 and 32, three SKPs after each
      reset = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         chk($sformatf("idle_out%0d", k), sym(out_k, out_data),
             (k == 16 || k == 32) ? 9'h1BC : (k >= 17 && k <= 19) ? 9'h11C : 9'h000);
         chk($sformatf("idle_sent%0d", k), skp_sent, (k == 19) ? 1 : 0);
         chk($sformatf("idle_pend%0d", k), skp_pending, (k == 15 || k == 31) ? 1 : 0);
      end

      // 40-symbol packet from cycle 2: SKP deferred, COM right after last symbol
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         chk($sformatf("pkt_ready%0d", i), in_ready, 1);
         in_valid = 1'b1;
         in_data = 8'(8'h40 + i);
         in_k = 1'b0;
         in_last = (i == 39);
         @(negedge clk);
         chk($sformatf("pkt_out%0d", i), sym(out_k, out_data), {1'b0, 8'(8'h40 + i)});
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      chk("pkt_pend_end", skp_pending, 1);
      chk("pkt_ready_end", in_ready, 0);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk($sformatf("pkt_skp_out%0d", j), sym(out_k, out_data), (j == 0) ? 9'h1BC : 9'h11C);
         chk($sformatf("pkt_skp_ready%0d", j), in_ready, (j < 3) ? 0 : 1);
      end

      // 5-symbol packet with a two-cycle gap
      do_reset();
      @(negedge clk);
      pd = '{8'hFB, 8'h11, 8'h00, 8'h00, 8'h22, 8'h33, 8'h44};
      pk = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      pv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      pl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 7; i++) begin
         in_valid = pv[i];
         in_data = pd[i];
         in_k = pk[i];
         in_last = pl[i];
         @(negedge clk);
         chk($sformatf("gap_out%0d", i), sym(out_k, out_data), {pk[i], pd[i]});
         chk($sformatf("gap_unf%0d", i), tx_underrun, pv[i] ? 0 : 1);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      @(negedge clk);
      chk("gap_after_out", sym(out_k, out_data), 9'h000);
      chk("gap_after_unf", tx_underrun, 0);

      // last symbol accepted on the edge the counter reaches 15
      do_reset();
      repeat (13) @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'hA5;
      in_last = 1'b0;
      @(negedge clk);
      chk("edge_out0", sym(out_k, out_data), 9'h0A5);
      in_data = 8'h5A;
      in_last = 1'b1;
      @(negedge clk);
      chk("edge_out1", sym(out_k, out_data), 9'h05A);
      chk("edge_pend", skp_pending, 1);
      in_valid = 1'b0;
      in_last = 1'b0;
      @(negedge clk);
      chk("edge_com", sym(out_k, out_data), 9'h1BC);

      // reset during the second SKP symbol
      do_reset();
      repeat (18) @(negedge clk);
      chk("mid_skp2", sym(out_k, out_data), 9'h11C);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_out", sym(out_k, out_data), 9'h000);
      chk("mid_rst_sent", skp_sent, 0);
      chk("mid_rst_ready", in_ready, 0);
      reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk($sformatf("mid_out%0d", k), sym(out_k, out_data), (k == 16) ? 9'h1BC : 9'h000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/tx_skp_scheduler.md
TX_SKP_SCHEDULER -- requirements
Module: tx_skp_scheduler

Interface
REQ-001 SHALL have parameter SKP_INTERVAL, default 1180; symbol cycles between SKP ordered-set starts when idle.
REQ-002 SHALL have parameter SKP_COUNT, default 3; number of SKP symbols following each COM; legal range 1..5.
REQ-003 clk  input  1  single clock; one symbol per cycle; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  8  MAC symbol byte.
REQ-006 in_k  input  1  in_data is a K-character.
REQ-007 in_valid  input  1  in_data/in_k/in_last valid this cycle.
REQ-008 in_last  input  1  last symbol of current packet.
REQ-009 in_ready  output  1  block accepts input this cycle; transfer = in_valid && in_ready.
REQ-010 out_data  output  8  symbol byte to 8b/10b encoder, registered.
REQ-011 out_k  output  1  out_data is a K-character, registered.
REQ-012 skp_pending  output  1  SKP insertion due but not yet started.
REQ-013 skp_sent  output  1  one-cycle pulse aligned with the last SKP symbol on out_data.
REQ-014 tx_underrun  output  1  one-cycle pulse: in_valid low while inside a packet.

Function
REQ-015 States SHALL be PASS, IN_PKT, SKP_SYM.
REQ-016 Interval counter SHALL clear to 0 on the edge that loads COM, else increment by 1, saturating at SKP_INTERVAL-1.
REQ-017 skp_pending SHALL equal (counter == SKP_INTERVAL-1) && state != SKP_SYM.
REQ-018 in_ready SHALL be 1 in IN_PKT, 1 in PASS when skp_pending=0, else 0; combinational from registered state only.
REQ-019 PASS, skp_pending=1: next edge SHALL load out_data=8'hBC, out_k=1 (COM), clear counter, set SKP index to 0, enter SKP_SYM.
REQ-020 PASS, transfer with in_last=0: next edge SHALL load the input symbol to out and enter IN_PKT.
REQ-021 PASS, transfer with in_last=1: single-symbol packet; SHALL load symbol and stay in PASS.
REQ-022 PASS, no transfer, skp_pending=0: SHALL load logical idle out_data=8'h00, out_k=0.
REQ-023 IN_PKT, transfer: SHALL load symbol; in_last=1 SHALL return to PASS.
REQ-024 IN_PKT, in_valid=0: SHALL load logical idle, remain IN_PKT, pulse tx_underrun on out-aligned cycle.
REQ-025 skp_pending SHALL never interrupt IN_PKT; insertion deferred until PASS; counter stays saturated meanwhile.
REQ-026 SKP_SYM: each edge SHALL load out_data=8'h1C, out_k=1; after SKP_COUNT SKP symbols SHALL return to PASS.
REQ-027 skp_sent SHALL be registered high exactly with the SKP_COUNT-th SKP symbol.
REQ-028 in_last accepted on same edge skp_pending rises: COM SHALL be the symbol immediately after the last packet symbol.
REQ-029 Data latency input-transfer to out_data SHALL be exactly 1 cycle; no input symbol dropped, duplicated or reordered.

Reset
REQ-030 While reset=1: state=PASS, counter=0, out_data=8'h00, out_k=0, skp_sent=0, tx_underrun=0, in_ready=0.
REQ-031 First edge with reset=0 SHALL resume normal operation from these values; reset mid-packet or mid-SKP SHALL abandon it with no partial-symbol completion.

Verification
REQ-032 Reset held 3 cycles -> out_data=8'h00, out_k=0, in_ready=0, pulses 0.
REQ-033 SKP_INTERVAL=16, SKP_COUNT=3, in_valid=0 -> COM 16 cycles after reset release, then 1C/K x3, skp_sent with third; COM-to-COM period 16.
REQ-034 SKP_INTERVAL=16, 40-symbol packet streamed from cycle 2 -> no COM inside packet; COM directly follows last symbol; in_ready=0 for 4 cycles.
REQ-035 Packet of 5 symbols with in_valid dropped 2 cycles mid-packet -> two 8'h00 on out, two tx_underrun pulses, payload order intact.
REQ-036 in_last accepted on edge where counter hits 15 -> next out symbol 8'hBC/K, no idle between.
REQ-037 reset asserted during second SKP symbol -> next cycle out=8'h00/0, counter=0, next COM 16 cycles after release.
